// File: rtl/cmul_seq_ctrl.sv
// Sequential complex multiplier: one shared 8x8 signed multiplier and one time-shared cla16 adder.
// Optional macro CMUL_CONJ_EN adds a conj input selecting A*conj(B).

module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [16:0] w_c;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // 4-bit lookahead groups; group carries resolved first, then carries inside each group
    always_comb begin
        w_c  = '0;
        w_gg = '0;
        w_gp = '0;
        for (int k = 0; k < 4; k++) begin
            w_gp[k] = &w_p[4*k +: 4];
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
        end
        w_c[0] = cin;
        for (int k = 0; k < 4; k++) begin
            w_c[4*k+4] = w_gg[k] | (w_gp[k] & w_c[4*k]);
        end
        for (int i = 0; i < 16; i++) begin
            if ((i % 4) != 3) begin
                w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
            end
        end
    end

    assign sum  = w_p ^ w_c[15:0];
    assign cout = w_c[16];
endmodule

module cmul_seq_ctrl #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] ar,
    input  logic [DW-1:0] ai,
    input  logic [DW-1:0] br,
    input  logic [DW-1:0] bi,
`ifdef CMUL_CONJ_EN
    input  logic          conj,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [16:0]   re_out,
    output logic [16:0]   im_out
);
    typedef enum logic [2:0] {
        S_IDLE, S_M0, S_M1, S_A0, S_M2, S_M3, S_A1, S_OUT
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic signed [7:0]    r_ar, r_ai, r_br, r_bi;
    logic [15:0]          r_p0, r_p1;
    logic [16:0]          r_re, r_im;
    logic                 w_conj;
    logic signed [7:0]    w_mul_a, w_mul_b;
    logic signed [15:0]   w_prod;
    logic [15:0]          w_add_a, w_add_b, w_sum;
    logic                 w_cin, w_cout;
    logic [16:0]          w_sum17;

`ifdef CMUL_CONJ_EN
    logic r_conj;
    assign w_conj = r_conj;
`else
    assign w_conj = 1'b0;
`endif

    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            S_M0:    begin w_mul_a = r_ar; w_mul_b = r_br; end
            S_M1:    begin w_mul_a = r_ai; w_mul_b = r_bi; end
            S_M2:    begin w_mul_a = r_ar; w_mul_b = r_bi; end
            S_M3:    begin w_mul_a = r_ai; w_mul_b = r_br; end
            default: ;
        endcase
    end

    assign w_prod = w_mul_a * w_mul_b;

    // Subtraction is a + ~b + 1; conj swaps which pass subtracts
    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        w_cin   = 1'b0;
        if (r_state == S_A0) begin
            w_add_a = r_p0;
            w_add_b = w_conj ? r_p1 : ~r_p1;
            w_cin   = ~w_conj;
        end else if (r_state == S_A1) begin
            w_add_a = w_conj ? r_p1  : r_p0;
            w_add_b = w_conj ? ~r_p0 : r_p1;
            w_cin   = w_conj;
        end
    end

    cla16 u_cla16 (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (w_cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Bit 16 is the sign extension of the 16-bit add, so the result is exact
    assign w_sum17 = {w_add_a[15] ^ w_add_b[15] ^ w_cout, w_sum};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_M0;
            S_M0:    w_state_nxt = S_M1;
            S_M1:    w_state_nxt = S_A0;
            S_A0:    w_state_nxt = S_M2;
            S_M2:    w_state_nxt = S_M3;
            S_M3:    w_state_nxt = S_A1;
            S_A1:    w_state_nxt = S_OUT;
            S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ar    <= '0;
            r_ai    <= '0;
            r_br    <= '0;
            r_bi    <= '0;
            r_p0    <= '0;
            r_p1    <= '0;
            r_re    <= '0;
            r_im    <= '0;
`ifdef CMUL_CONJ_EN
            r_conj  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && in_valid) begin
                r_ar <= ar;
                r_ai <= ai;
                r_br <= br;
                r_bi <= bi;
`ifdef CMUL_CONJ_EN
                r_conj <= conj;
`endif
            end
            case (r_state)
                S_M0, S_M2: r_p0 <= w_prod;
                S_M1, S_M3: r_p1 <= w_prod;
                S_A0:       r_re <= w_sum17;
                S_A1:       r_im <= w_sum17;
                default:    ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign re_out    = r_re;
    assign im_out    = r_im;
endmodule
